// File: rtl/spi_ram_burst.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_burst
//  Description : Command-driven single-port RAM behind an SPI slave byte
//                interface. Each accepted word carries a 2-bit opcode plus
//                payload: load write address, write data, load read address,
//                read data. Optional post-access address auto-increment
//                gives burst transfers; accesses beyond MEM_DEPTH pulse err.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_burst #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [ADDR_SIZE+1:0] din,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 err
);

  localparam int                 c_IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int                 c_LAST_I = MEM_DEPTH - 1;
  localparam logic [ADDR_SIZE:0] c_LAST   = c_LAST_I[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE-1:0] c_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic               c_INC    = (AUTO_INC != 0);

  localparam logic [1:0] c_OP_WADDR = 2'b00;
  localparam logic [1:0] c_OP_WDATA = 2'b01;
  localparam logic [1:0] c_OP_RADDR = 2'b10;
  localparam logic [1:0] c_OP_RDATA = 2'b11;

  // Storage and pointers
  logic [ADDR_SIZE-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [ADDR_SIZE-1:0] r_tx_data;
  logic                 r_tx_valid;
  logic                 r_err;

  // Decode helpers
  logic [1:0]           w_op;
  logic [ADDR_SIZE-1:0] w_pl;
  logic                 w_wr_oor;
  logic                 w_rd_oor;
  logic [ADDR_SIZE-1:0] w_wr_next;
  logic [ADDR_SIZE-1:0] w_rd_next;
  logic [ADDR_SIZE-1:0] w_rd_word;

  // Next-state values
  logic                 w_mem_we;
  logic [ADDR_SIZE-1:0] w_wr_addr_d;
  logic [ADDR_SIZE-1:0] w_rd_addr_d;
  logic [ADDR_SIZE-1:0] w_tx_data_d;
  logic                 w_tx_valid_d;
  logic                 w_err_d;

  assign w_op = din[ADDR_SIZE+1:ADDR_SIZE];
  assign w_pl = din[ADDR_SIZE-1:0];

  // A memory that fills the whole address space can never be addressed out
  // of range, so the comparator is only built for a partial map.
  generate
    if (MEM_DEPTH >= (1 << ADDR_SIZE)) begin : g_full_map
      assign w_wr_oor = 1'b0;
      assign w_rd_oor = 1'b0;
    end else begin : g_partial_map
      assign w_wr_oor = ({1'b0, r_wr_addr} > c_LAST);
      assign w_rd_oor = ({1'b0, r_rd_addr} > c_LAST);
    end
  endgenerate

  // Pointers wrap to zero from the last valid word or from anywhere above it
  assign w_wr_next = ({1'b0, r_wr_addr} >= c_LAST) ? '0 : (r_wr_addr + c_ONE);
  assign w_rd_next = ({1'b0, r_rd_addr} >= c_LAST) ? '0 : (r_rd_addr + c_ONE);

  // Out-of-range reads return zero rather than touching the array
  assign w_rd_word = w_rd_oor ? '0 : r_mem[r_rd_addr[c_IDX_W-1:0]];

  // Command decode: one command per rx_valid cycle
  always_comb begin
    w_mem_we     = 1'b0;
    w_wr_addr_d  = r_wr_addr;
    w_rd_addr_d  = r_rd_addr;
    w_tx_data_d  = r_tx_data;
    w_tx_valid_d = 1'b0;
    w_err_d      = 1'b0;
    if (rx_valid) begin
      case (w_op)
        c_OP_WADDR: w_wr_addr_d = w_pl;
        c_OP_WDATA: begin
          w_mem_we = ~w_wr_oor;
          w_err_d  = w_wr_oor;
          if (c_INC) w_wr_addr_d = w_wr_next;
        end
        c_OP_RADDR: w_rd_addr_d = w_pl;
        c_OP_RDATA: begin
          w_tx_data_d  = w_rd_word;
          w_tx_valid_d = 1'b1;
          w_err_d      = w_rd_oor;
          if (c_INC) w_rd_addr_d = w_rd_next;
        end
        default: w_err_d = 1'b0;
      endcase
    end
  end

  // Control and output registers; reset discards the command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_addr  <= w_wr_addr_d;
      r_rd_addr  <= w_rd_addr_d;
      r_tx_data  <= w_tx_data_d;
      r_tx_valid <= w_tx_valid_d;
      r_err      <= w_err_d;
    end
  end

  // Memory array write port; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[r_wr_addr[c_IDX_W-1:0]] <= w_pl;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_burst
//  Description : Directed bench for spi_ram_burst. Three instances cover the
//                default map, AUTO_INC=0 and a 200-word map. Read results are
//                queued as they are issued and popped when tx_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_burst;

  typedef struct {
    int         dut;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rxv     [3];
  logic [9:0] din;
  logic [7:0] txd     [3];
  logic       txv     [3];
  logic       er      [3];

  logic       exp_txv [3];
  logic       exp_err [3];
  logic       exp_rst;
  logic [7:0] last    [3];
  logic       mon_en;
  logic       final_chk;
  exp_t       sbq[$];
  int         tests;
  int         fails;

  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut0 (
    .clk(clk), .rst(rst), .rx_valid(rxv[0]), .din(din),
    .tx_data(txd[0]), .tx_valid(txv[0]), .err(er[0]));

  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut1 (
    .clk(clk), .rst(rst), .rx_valid(rxv[1]), .din(din),
    .tx_data(txd[1]), .tx_valid(txv[1]), .err(er[1]));

  spi_ram_burst #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut2 (
    .clk(clk), .rst(rst), .rx_valid(rxv[2]), .din(din),
    .tx_data(txd[2]), .tx_valid(txv[2]), .err(er[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs registered at the previous rising edge are compared on
  // the falling edge against the expectations set with that command.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (exp_rst) last[d] = 8'h00;
        tests++;
        assert (txv[d] === exp_txv[d]) else begin
          fails++;
          $error("FAIL tx_valid[%0d] observed=%b expected=%b", d, txv[d], exp_txv[d]);
        end
        tests++;
        assert (er[d] === exp_err[d]) else begin
          fails++;
          $error("FAIL err[%0d] observed=%b expected=%b", d, er[d], exp_err[d]);
        end
        if (txv[d] === 1'b1) begin
          tests++;
          assert (sbq.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_tx[%0d] observed=%h expected=none", d, txd[d]);
          end
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            tests++;
            assert (e.dut == d && txd[d] === e.data) else begin
              fails++;
              $error("FAIL tx_data[%0d] observed=%h expected=%h (dut %0d)", d, txd[d], e.data, e.dut);
            end
            last[d] = e.data;
          end
        end else begin
          tests++;
          assert (txd[d] === last[d]) else begin
            fails++;
            $error("FAIL tx_hold[%0d] observed=%h expected=%h", d, txd[d], last[d]);
          end
        end
      end
      if (final_chk) begin
        tests++;
        assert (sbq.size() == 0) else begin
          fails++;
          $error("FAIL missing_reads observed=%0d expected=0", sbq.size());
        end
      end
    end
  end

  task automatic clear_drive();
    rst     = 1'b0;
    exp_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rxv[k]     = 1'b0;
      exp_txv[k] = 1'b0;
      exp_err[k] = 1'b0;
    end
  endtask

  // One command to one instance; read-data commands queue the expected word
  task automatic step(input int d, input logic [1:0] op, input logic [7:0] pl,
                      input logic [7:0] ed, input logic ee);
    clear_drive();
    rxv[d]     = 1'b1;
    din        = {op, pl};
    exp_err[d] = ee;
    if (op == 2'b11) begin
      exp_txv[d] = 1'b1;
      sbq.push_back('{dut: d, data: ed});
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_drive();
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reset cycle with a live command that must be dropped
  task automatic rst_step(input int d, input logic [1:0] op, input logic [7:0] pl);
    clear_drive();
    rst     = 1'b1;
    exp_rst = 1'b1;
    rxv[d]  = 1'b1;
    din     = {op, pl};
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    final_chk = 1'b0;
    din       = '0;
    for (int k = 0; k < 3; k++) last[k] = 8'h00;
    clear_drive();
    rst     = 1'b1;
    exp_rst = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    #1;

    // Burst write then burst read, back-to-back tx_valid pulses
    step(0, 2'b00, 8'h10, 8'h00, 1'b0);
    step(0, 2'b01, 8'hA1, 8'h00, 1'b0);
    step(0, 2'b01, 8'hA2, 8'h00, 1'b0);
    step(0, 2'b01, 8'hA3, 8'h00, 1'b0);
    step(0, 2'b10, 8'h10, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'hA1, 1'b0);
    step(0, 2'b11, 8'h5A, 8'hA2, 1'b0);
    step(0, 2'b11, 8'hFF, 8'hA3, 1'b0);

    // Wrap from 255 to 0 for both pointers
    step(0, 2'b00, 8'hFF, 8'h00, 1'b0);
    step(0, 2'b01, 8'h55, 8'h00, 1'b0);
    step(0, 2'b01, 8'h66, 8'h00, 1'b0);
    step(0, 2'b10, 8'hFF, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'h55, 1'b0);
    step(0, 2'b11, 8'h00, 8'h66, 1'b0);
    step(0, 2'b10, 8'h00, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'h66, 1'b0);

    // Idle gap: single pulse, data held, read pointer untouched
    step(0, 2'b10, 8'h11, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'hA2, 1'b0);
    idle(3);
    step(0, 2'b11, 8'h00, 8'hA3, 1'b0);

    // AUTO_INC=0: repeated writes hit one address, neighbour untouched
    step(1, 2'b00, 8'h06, 8'h00, 1'b0);
    step(1, 2'b01, 8'hEE, 8'h00, 1'b0);
    step(1, 2'b00, 8'h05, 8'h00, 1'b0);
    step(1, 2'b01, 8'h11, 8'h00, 1'b0);
    step(1, 2'b01, 8'h22, 8'h00, 1'b0);
    step(1, 2'b10, 8'h05, 8'h00, 1'b0);
    step(1, 2'b11, 8'h00, 8'h22, 1'b0);
    step(1, 2'b11, 8'h00, 8'h22, 1'b0);
    step(1, 2'b10, 8'h06, 8'h00, 1'b0);
    step(1, 2'b11, 8'h00, 8'hEE, 1'b0);

    // MEM_DEPTH=200: out-of-range write/read, wrap at 199 and at 255
    step(2, 2'b00, 8'hC8, 8'h00, 1'b0);
    step(2, 2'b01, 8'h77, 8'h00, 1'b1);
    step(2, 2'b10, 8'hC8, 8'h00, 1'b0);
    step(2, 2'b11, 8'h00, 8'h00, 1'b1);
    step(2, 2'b00, 8'hC7, 8'h00, 1'b0);
    step(2, 2'b01, 8'h44, 8'h00, 1'b0);
    step(2, 2'b01, 8'h45, 8'h00, 1'b0);
    step(2, 2'b10, 8'hC7, 8'h00, 1'b0);
    step(2, 2'b11, 8'h00, 8'h44, 1'b0);
    step(2, 2'b11, 8'h00, 8'h45, 1'b0);
    step(2, 2'b00, 8'hFF, 8'h00, 1'b0);
    step(2, 2'b01, 8'h46, 8'h00, 1'b1);
    step(2, 2'b01, 8'h47, 8'h00, 1'b0);
    step(2, 2'b10, 8'hFF, 8'h00, 1'b0);
    step(2, 2'b11, 8'h00, 8'h00, 1'b1);
    step(2, 2'b11, 8'h00, 8'h47, 1'b0);

    // Reset mid-burst: dropped word, pointers and outputs cleared
    step(0, 2'b00, 8'h21, 8'h00, 1'b0);
    step(0, 2'b01, 8'hC0, 8'h00, 1'b0);
    step(0, 2'b00, 8'h20, 8'h00, 1'b0);
    step(0, 2'b01, 8'hB1, 8'h00, 1'b0);
    rst_step(0, 2'b01, 8'hB2);
    step(0, 2'b01, 8'h99, 8'h00, 1'b0);
    step(0, 2'b10, 8'h00, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'h99, 1'b0);
    step(0, 2'b10, 8'h21, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'hC0, 1'b0);
    step(0, 2'b10, 8'h20, 8'h00, 1'b0);
    step(0, 2'b11, 8'h00, 8'hB1, 1'b0);

    idle(1);
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
